mlaccel_memarb: RTL

Two-client arbiter for the shared `mlaccel_memory` port. It sits between the host command engine (QPI wmem/rmem path) and the sequencer fetch port (`smem`). Each cycle it grants at most one request, drives the memory address, write-enable and write-data combinationally, and tags in-flight reads. It returns each read response to the client that issued it after the fixed memory latency.

---
 rtl/mlaccel_pkg.sv | 11 +
 rtl/mlaccel_memarb_tagpipe.sv | 36 +++
 rtl/mlaccel_memarb.sv | 104 ++++++++++
 3 files changed

// File: rtl/mlaccel_pkg.sv
// Shared constants for the mlaccel memory arbiter: client encoding, bus widths, default latency.
package mlaccel_pkg;

    localparam logic CLIENT_HOST = 1'b0;
    localparam logic CLIENT_SEQ  = 1'b1;

    localparam int MLACCEL_ADDR_W  = 16;
    localparam int MLACCEL_RDATA_W = 64;
    localparam int MLACCEL_MEM_LAT = 2;

endpackage

// File: rtl/mlaccel_memarb_tagpipe.sv
// MEM_LAT-deep {valid, client} shift register tracking in-flight reads; the tail marks the response cycle.
// Latency MEM_LAT cycles from load to tail; no backpressure, shifts every cycle.
module mlaccel_memarb_tagpipe
    import mlaccel_pkg::*;
#(
    parameter int MEM_LAT = MLACCEL_MEM_LAT
) (
    input  logic clock,
    input  logic reset,
    input  logic load_valid,
    input  logic load_client,
    output logic tail_valid,
    output logic tail_client
);

    logic [MEM_LAT-1:0] stage_valid;
    logic [MEM_LAT-1:0] stage_client;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stage_valid  <= '0;
            stage_client <= '0;
        end else begin
            stage_valid[0]  <= load_valid;
            stage_client[0] <= load_client;
            for (int i = 1; i < MEM_LAT; i++) begin
                stage_valid[i]  <= stage_valid[i-1];
                stage_client[i] <= stage_client[i-1];
            end
        end
    end

    assign tail_valid  = stage_valid[MEM_LAT-1];
    assign tail_client = stage_client[MEM_LAT-1];

endmodule

// File: rtl/mlaccel_memarb.sv
// Two-client (host / sequencer) arbiter for the shared memory port; optional MLACCEL_MEMARB_RR_EN selects round-robin.
// Grant is combinational, read responses return MEM_LAT cycles after grant; no backpressure on responses.
module mlaccel_memarb
    import mlaccel_pkg::*;
#(
    parameter int MEM_LAT        = MLACCEL_MEM_LAT,
    parameter int HOST_BURST_MAX = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       h_valid,
    output logic                       h_ready,
    input  logic [MLACCEL_ADDR_W-1:0]  h_addr,
    input  logic [1:0]                 h_wen,
    input  logic [15:0]                h_wdata,
    output logic                       h_rvalid,
    output logic [15:0]                h_rdata,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [MLACCEL_ADDR_W-1:0]  s_addr,
    output logic                       s_rvalid,
    output logic [31:0]                s_rdata,
    output logic [MLACCEL_ADDR_W-1:0]  mem_addr,
    output logic [1:0]                 mem_wen,
    output logic [15:0]                mem_wdata,
    input  logic [MLACCEL_RDATA_W-1:0] mem_rdata
);

    logic h_grant;
    logic s_grant;

`ifdef MLACCEL_MEMARB_RR_EN
    logic last_client;

    // On a collision the client that was not granted most recently wins.
    always_comb begin
        h_grant = !reset && h_valid && (!s_valid || last_client == CLIENT_SEQ);
        s_grant = !reset && s_valid && !h_grant;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)        last_client <= CLIENT_HOST;
        else if (h_grant) last_client <= CLIENT_HOST;
        else if (s_grant) last_client <= CLIENT_SEQ;
    end
`else
    localparam logic [2:0] BURST_LIM = 3'(HOST_BURST_MAX);
    logic [2:0] burst_cnt;

    // Host has priority until it has taken BURST_LIM grants in front of a waiting sequencer.
    always_comb begin
        h_grant = !reset && h_valid && !(s_valid && burst_cnt == BURST_LIM);
        s_grant = !reset && s_valid && !h_grant;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)                             burst_cnt <= '0;
        else if (!s_valid || s_grant)          burst_cnt <= '0;
        else if (h_grant && burst_cnt != BURST_LIM) burst_cnt <= burst_cnt + 3'd1;
    end
`endif

    assign h_ready = h_grant;
    assign s_ready = s_grant;

    always_comb begin
        mem_addr  = '0;
        mem_wen   = '0;
        mem_wdata = '0;
        if (h_grant) begin
            mem_addr  = h_addr;
            mem_wen   = h_wen;
            mem_wdata = h_wdata;
        end else if (s_grant) begin
            mem_addr  = s_addr;
        end
    end

    logic rd_grant;
    logic rd_client;
    logic tail_valid;
    logic tail_client;

    assign rd_grant  = (h_grant && h_wen == 2'b00) || s_grant;
    assign rd_client = s_grant ? CLIENT_SEQ : CLIENT_HOST;

    mlaccel_memarb_tagpipe #(.MEM_LAT(MEM_LAT)) u_tagpipe (
        .clock       (clock),
        .reset       (reset),
        .load_valid  (rd_grant),
        .load_client (rd_client),
        .tail_valid  (tail_valid),
        .tail_client (tail_client)
    );

    assign h_rvalid = tail_valid && tail_client == CLIENT_HOST;
    assign s_rvalid = tail_valid && tail_client == CLIENT_SEQ;
    assign h_rdata  = mem_rdata[15:0];
    assign s_rdata  = mem_rdata[31:0];

    logic rdata_hi_unused;
    assign rdata_hi_unused = ^mem_rdata[MLACCEL_RDATA_W-1:32];

endmodule
